step_clock_ctrl: RTL and testbench

Parametrised successor to the board-level run/step/fast human-clock counter. It produces a one-Clock-cycle CPU clock enable from debounced run/step/fast controls, with selectable slow/fast rates, multi-instruction step bursts, NUM_BP PC breakpoints and an optional sticky monitor trip. It sits between the debouncers and the CPU on the board top; the CPU runs on Clock gated by `cpu_en`.

---
 rtl/step_clock_pkg.sv | 20 ++
 rtl/step_clock_ctrl_if.sv | 49 ++++
 rtl/bp_match.sv | 33 +++
 rtl/step_clock_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_step_clock_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_clock_pkg.sv
// step_clock_pkg
// Shared types for the step/run/fast CPU clock controller.
//   state_t      : controller states (STOP, RUN, BURST, BREAK)
//   halt_cause_t : why the controller is sitting in BREAK
package step_clock_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        BURST = 2'd2,
        BREAK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_BP   = 2'd1,
        CAUSE_TRIP = 2'd2
    } halt_cause_t;

endpackage

// File: rtl/step_clock_ctrl_if.sv
// step_clock_ctrl_if
// Groups the board-side controls and CPU-side status of step_clock_ctrl.
//   master modport : board top / debouncers / CPU (drives controls, pc and breakpoints)
//   slave modport  : the controller (drives cpu_en and the status outputs)
// Signals:
//   run, fast, step : debounced level controls
//   burst_n         : instructions per step (0 behaves as 1)
//   pc              : current CPU program counter
//   bp_addr         : NUM_BP packed breakpoint addresses, channel i at [i*PC_W +: PC_W]
//   bp_valid        : per-channel breakpoint enable
//   monitor_in      : trip input (only used when STEP_CLOCK_MONITOR_TRIP_EN is defined)
//   cpu_en          : one-cycle CPU clock enable
//   human_clock     : toggles on every cpu_en (LED)
//   halted          : 1 while in BREAK
//   halt_cause      : reason for the last break
//   bp_hit_idx      : channel responsible for the last breakpoint break
interface step_clock_ctrl_if #(
    parameter int PC_W    = 6,
    parameter int NUM_BP  = 4,
    parameter int BURST_W = 4
) ();
    import step_clock_pkg::*;

    logic                     run;
    logic                     fast;
    logic                     step;
    logic [BURST_W-1:0]       burst_n;
    logic [PC_W-1:0]          pc;
    logic [NUM_BP*PC_W-1:0]   bp_addr;
    logic [NUM_BP-1:0]        bp_valid;
    logic                     monitor_in;

    logic                     cpu_en;
    logic                     human_clock;
    logic                     halted;
    halt_cause_t              halt_cause;
    logic [2:0]               bp_hit_idx;

    modport master (
        output run, fast, step, burst_n, pc, bp_addr, bp_valid, monitor_in,
        input  cpu_en, human_clock, halted, halt_cause, bp_hit_idx
    );

    modport slave (
        input  run, fast, step, burst_n, pc, bp_addr, bp_valid, monitor_in,
        output cpu_en, human_clock, halted, halt_cause, bp_hit_idx
    );

endinterface

// File: rtl/bp_match.sv
// bp_match
// NUM_BP parallel PC comparators followed by a lowest-index priority encoder.
// Ports:
//   pc       in  PC_W         : current program counter
//   bp_addr  in  NUM_BP*PC_W  : packed breakpoint addresses
//   bp_valid in  NUM_BP       : per-channel enable
//   hit      out 1            : some enabled channel matches pc
//   idx      out 3            : lowest matching channel (0 when no hit)
module bp_match #(
    parameter int PC_W   = 6,
    parameter int NUM_BP = 4
) (
    input  logic [PC_W-1:0]        pc,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_valid,
    output logic                   hit,
    output logic [2:0]             idx
);

    // Walk from the top channel down so the lowest matching channel is the
    // last one written and therefore wins.
    always_comb begin
        hit = 1'b0;
        idx = 3'd0;
        for (int i = NUM_BP - 1; i >= 0; i--) begin
            if (bp_valid[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
                hit = 1'b1;
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/step_clock_ctrl.sv
// step_clock_ctrl
// Human-speed CPU clock controller: produces a one-cycle CPU clock enable from
// debounced run/step/fast controls with slow/fast rates, multi-instruction step
// bursts and NUM_BP program-counter breakpoints.
// Optional feature: define STEP_CLOCK_MONITOR_TRIP_EN to enable the sticky
// monitor trip (rising edge on monitor_in forces BREAK until reset).
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high reset
//   bus   : step_clock_ctrl_if.slave (controls in, cpu_en and status out)
module step_clock_ctrl
    import step_clock_pkg::*;
#(
    parameter int SLOW_DIV = 50_000_000,
    parameter int FAST_DIV = 5_000_000,
    parameter int PC_W     = 6,
    parameter int NUM_BP   = 4,
    parameter int BURST_W  = 4
) (
    input logic             clock,
    input logic             reset,
    step_clock_ctrl_if.slave bus
);

    localparam int                 CNT_W     = $clog2(SLOW_DIV) + 1;
    localparam logic [CNT_W-1:0]   SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0]   FAST_LAST = CNT_W'(FAST_DIV - 1);
    localparam logic [BURST_W-1:0] ONE_INSTR = BURST_W'(1);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   div_last;
    logic [BURST_W-1:0] remain;
    logic               skip;
    logic               step_q;
    logic               human_clock_q;
    logic               halted_q;
    halt_cause_t        halt_cause_q;
    logic [2:0]         bp_hit_idx_q;

    logic               active;
    logic               tick;
    logic               step_edge;
    logic               bp_any;
    logic [2:0]         bp_idx;
    logic               bp_hit;
    logic               trip_edge;
    logic               trip_hold;
    logic               cpu_en;

    bp_match #(
        .PC_W   (PC_W),
        .NUM_BP (NUM_BP)
    ) u_bp_match (
        .pc       (bus.pc),
        .bp_addr  (bus.bp_addr),
        .bp_valid (bus.bp_valid),
        .hit      (bp_any),
        .idx      (bp_idx)
    );

    // The divider compares against the currently selected rate, so changing
    // fast mid-count with cnt already past the new limit fires straight away.
    assign active    = (state == RUN) || (state == BURST);
    assign div_last  = bus.fast ? FAST_LAST : SLOW_LAST;
    assign tick      = active && (cnt >= div_last);
    assign step_edge = bus.step & ~step_q;
    assign bp_hit    = active && !skip && bp_any;
    assign cpu_en    = tick && !bp_hit && !trip_edge;

`ifdef STEP_CLOCK_MONITOR_TRIP_EN
    logic trip;
    logic mon_q;

    // Monitor trip: edge-detect monitor_in and latch a sticky trip flag that
    // keeps the controller in BREAK until reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mon_q <= 1'b0;
            trip  <= 1'b0;
        end else begin
            mon_q <= bus.monitor_in;
            if (trip_edge) begin
                trip <= 1'b1;
            end
        end
    end

    assign trip_edge = bus.monitor_in & ~mon_q;
    assign trip_hold = trip;
`else
    logic unused_monitor;

    assign unused_monitor = bus.monitor_in;
    assign trip_edge      = 1'b0;
    assign trip_hold      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= STOP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Run/step handling first, then breakpoint and trip
    // override it so the higher-priority break always wins.
    always_comb begin
        next_state = state;
        case (state)
            STOP: begin
                if (bus.run) begin
                    next_state = RUN;
                end else if (step_edge) begin
                    next_state = BURST;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    next_state = STOP;
                end
            end
            BURST: begin
                if (cpu_en && (remain == ONE_INSTR)) begin
                    next_state = STOP;
                end
            end
            BREAK: begin
                if (step_edge && !trip_hold) begin
                    next_state = STOP;
                end
            end
            default: next_state = STOP;
        endcase
        if (bp_hit) begin
            next_state = BREAK;
        end
        if (trip_edge) begin
            next_state = BREAK;
        end
    end

    // Divider, burst counter, skip flag and registered outputs. cnt only
    // advances while staying in RUN/BURST, so any entry starts from zero.
    // skip lets the CPU execute the instruction at a breakpoint address
    // after the user steps off it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            remain        <= '0;
            skip          <= 1'b0;
            step_q        <= 1'b0;
            human_clock_q <= 1'b0;
            halted_q      <= 1'b0;
            halt_cause_q  <= CAUSE_NONE;
            bp_hit_idx_q  <= 3'd0;
        end else begin
            step_q        <= bus.step;
            human_clock_q <= human_clock_q ^ cpu_en;
            halted_q      <= (next_state == BREAK);

            if (active && !tick && (next_state == state)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end

            if ((state == STOP) && (next_state == BURST)) begin
                remain <= (bus.burst_n == '0) ? ONE_INSTR : bus.burst_n;
            end else if ((state == BURST) && cpu_en) begin
                remain <= remain - ONE_INSTR;
            end

            if ((state == BREAK) && (next_state != BREAK)) begin
                skip <= 1'b1;
            end else if (cpu_en) begin
                skip <= 1'b0;
            end

            if (trip_edge) begin
                halt_cause_q <= CAUSE_TRIP;
            end else if (bp_hit) begin
                halt_cause_q <= CAUSE_BP;
                bp_hit_idx_q <= bp_idx;
            end
        end
    end

    assign bus.cpu_en      = cpu_en;
    assign bus.human_clock = human_clock_q;
    assign bus.halted      = halted_q;
    assign bus.halt_cause  = halt_cause_q;
    assign bus.bp_hit_idx  = bp_hit_idx_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// tb_step_clock_ctrl
// Self-checking bench for step_clock_ctrl (SLOW_DIV=4, FAST_DIV=2, NUM_BP=2,
// PC_W=6). A behavioural model predicts enable and break events into queues;
// a monitor process pops and compares them when the DUT presents cpu_en or a
// rising halted. Define STEP_CLOCK_MONITOR_TRIP_EN to exercise the trip feature.
module tb_step_clock_ctrl;
    import step_clock_pkg::*;

    localparam int SLOW_DIV = 4;
    localparam int FAST_DIV = 2;
    localparam int PC_W     = 6;
    localparam int NUM_BP   = 2;
    localparam int BURST_W  = 4;

    typedef struct {
        int cyc;
        int parity;
    } en_ev_t;

    typedef struct {
        int cyc;
        int cause;
        int idx;
    } brk_ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   en_count = 0;
    bit   pc_follow = 1'b0;

    en_ev_t  en_q[$];
    brk_ev_t brk_q[$];

    // Behavioural model state.
    bit m_free;
    int m_burst_left;
    bit m_halted;
    int m_elapsed;
    bit m_skip;
    bit m_prev_step;
    bit m_prev_mon;
    bit m_trip;
    int m_enables;
    int m_last_idx;

    step_clock_ctrl_if #(.PC_W(PC_W), .NUM_BP(NUM_BP), .BURST_W(BURST_W)) bus ();

    step_clock_ctrl #(
        .SLOW_DIV (SLOW_DIV),
        .FAST_DIV (FAST_DIV),
        .PC_W     (PC_W),
        .NUM_BP   (NUM_BP),
        .BURST_W  (BURST_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic model_reset();
        m_free       = 1'b0;
        m_burst_left = 0;
        m_halted     = 1'b0;
        m_elapsed    = 0;
        m_skip       = 1'b0;
        m_prev_step  = 1'b0;
        m_prev_mon   = 1'b0;
        m_trip       = 1'b0;
        m_enables    = 0;
        m_last_idx   = 0;
        en_q.delete();
        brk_q.delete();
    endtask

    // One cycle of the reference behaviour, evaluated on the inputs that are
    // stable during this cycle.
    task automatic model_cycle();
        int d;
        int hit_idx;
        bit step_rise;
        bit active;
        bit trip_rise;
        bit fire;
        d         = bus.fast ? FAST_DIV : SLOW_DIV;
        step_rise = bus.step && !m_prev_step;
        active    = m_free || (m_burst_left > 0);
        trip_rise = 1'b0;
`ifdef STEP_CLOCK_MONITOR_TRIP_EN
        trip_rise = bus.monitor_in && !m_prev_mon;
`endif
        hit_idx = -1;
        if (active && !m_skip) begin
            for (int i = 0; i < NUM_BP; i++) begin
                if (hit_idx < 0 && bus.bp_valid[i] && bus.bp_addr[i*PC_W +: PC_W] == bus.pc) begin
                    hit_idx = i;
                end
            end
        end
        fire = active && (m_elapsed + 1 >= d) && (hit_idx < 0) && !trip_rise;
        if (fire) begin
            en_q.push_back('{cyc, m_enables % 2});
            m_enables++;
            m_skip = 1'b0;
        end
        if (trip_rise) begin
            if (!m_halted) brk_q.push_back('{cyc + 1, 2, m_last_idx});
            m_trip = 1'b1;
            m_halted = 1'b1;
            m_free = 1'b0;
            m_burst_left = 0;
            m_elapsed = 0;
        end else if (hit_idx >= 0) begin
            brk_q.push_back('{cyc + 1, 1, hit_idx});
            m_last_idx = hit_idx;
            m_halted = 1'b1;
            m_free = 1'b0;
            m_burst_left = 0;
            m_elapsed = 0;
        end else if (m_halted) begin
            if (step_rise && !m_trip) begin
                m_halted = 1'b0;
                m_skip = 1'b1;
            end
        end else if (m_free) begin
            if (!bus.run) begin
                m_free = 1'b0;
                m_elapsed = 0;
            end else begin
                m_elapsed = fire ? 0 : m_elapsed + 1;
            end
        end else if (m_burst_left > 0) begin
            if (fire) begin
                m_burst_left--;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end else begin
            if (bus.run) begin
                m_free = 1'b1;
                m_elapsed = 0;
            end else if (step_rise) begin
                m_burst_left = (bus.burst_n == 0) ? 1 : int'(bus.burst_n);
                m_elapsed = 0;
            end
        end
        m_prev_step = bus.step;
        m_prev_mon  = bus.monitor_in;
    endtask

    // Reference model: predicts events at each negedge.
    always @(negedge clock) begin
        if (reset) model_reset();
        else model_cycle();
    end

    // Monitor: compares DUT events against the predicted queues.
    bit prev_halted = 1'b0;
    always @(negedge clock) begin
        en_ev_t  e;
        brk_ev_t b;
        #1;
        if (reset) begin
            prev_halted = 1'b0;
        end else begin
            while (en_q.size() > 0 && en_q[0].cyc < cyc) begin
                e = en_q.pop_front();
                check_output("enable_missing", 0, e.cyc);
            end
            while (brk_q.size() > 0 && brk_q[0].cyc < cyc) begin
                b = brk_q.pop_front();
                check_output("break_missing", 0, b.cyc);
            end
            if (bus.cpu_en) begin
                en_count++;
                if (en_q.size() == 0) begin
                    check_output("unexpected_enable", 1, 0);
                end else begin
                    e = en_q.pop_front();
                    check_output("enable_cycle", cyc, e.cyc);
                    check_output("human_clock_phase", bus.human_clock, e.parity);
                end
            end
            if (bus.halted && !prev_halted) begin
                if (brk_q.size() == 0) begin
                    check_output("unexpected_break", 1, 0);
                end else begin
                    b = brk_q.pop_front();
                    check_output("break_cycle", cyc, b.cyc);
                    check_output("halt_cause", bus.halt_cause, b.cause);
                    if (b.cause == 1) check_output("bp_hit_idx", bus.bp_hit_idx, b.idx);
                end
            end
            prev_halted = bus.halted;
        end
    end

    // Advance n cycles; optionally let pc follow cpu_en like a CPU would.
    task automatic run_cycles(input int n);
        bit en_now;
        repeat (n) begin
            @(negedge clock);
            #2;
            en_now = bus.cpu_en;
            @(posedge clock);
            #1;
            if (pc_follow && en_now) bus.pc = bus.pc + 6'd1;
        end
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        run_cycles(1);
        bus.step = 1'b0;
        run_cycles(1);
    endtask

    // One randomised soak cycle.
    task automatic apply_stimulus();
        if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
        if ($urandom_range(0, 3) == 0) bus.fast = ~bus.fast;
        if ($urandom_range(0, 5) == 0) bus.step = ~bus.step;
        if ($urandom_range(0, 7) == 0) bus.burst_n = 4'($urandom_range(0, 3));
        if (!pc_follow && $urandom_range(0, 3) == 0) bus.pc = 6'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0) bus.bp_valid = 2'($urandom_range(0, 3));
`ifndef STEP_CLOCK_MONITOR_TRIP_EN
        if ($urandom_range(0, 9) == 0) bus.monitor_in = ~bus.monitor_in;
`endif
        run_cycles(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int bn;
        int h;
        bus.run        = 1'b0;
        bus.fast       = 1'b0;
        bus.step       = 1'b0;
        bus.burst_n    = '0;
        bus.pc         = '0;
        bus.bp_addr    = '0;
        bus.bp_valid   = '0;
        bus.monitor_in = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_cpu_en", bus.cpu_en, 0);
        check_output("reset_human_clock", bus.human_clock, 0);
        check_output("reset_halted", bus.halted, 0);
        check_output("reset_halt_cause", bus.halt_cause, 0);
        check_output("reset_bp_hit_idx", bus.bp_hit_idx, 0);
        reset = 1'b0;
        run_cycles(2);

        // Free run, slow then fast.
        base = en_count;
        bus.run = 1'b1;
        run_cycles(20);
        check_output("run_slow_count", en_count - base, 4);
        base = en_count;
        bus.fast = 1'b1;
        run_cycles(12);
        check_output("run_fast_count", en_count - base, 6);
        bus.run = 1'b0;
        bus.fast = 1'b0;
        run_cycles(4);

        // Step bursts, step sometimes held high for a long time.
        for (int i = 0; i < 6; i++) begin
            bn = (i == 0) ? 3 : (i == 1) ? 0 : $urandom_range(0, 4);
            h  = (i == 2) ? 30 : $urandom_range(1, 20);
            bus.burst_n = 4'(bn);
            base = en_count;
            bus.step = 1'b1;
            run_cycles(h);
            bus.step = 1'b0;
            run_cycles(34 - h);
            check_output("burst_count", en_count - base, (bn == 0) ? 1 : bn);
        end

        // Breakpoint on pc=5 on both channels.
        bus.bp_addr  = {6'd5, 6'd5};
        bus.bp_valid = 2'b11;
        bus.pc       = '0;
        pc_follow    = 1'b1;
        bus.run      = 1'b1;
        for (int k = 0; k < 40; k++) begin
            run_cycles(1);
            if (bus.halted) break;
        end
        check_output("bp_halted", bus.halted, 1);
        check_output("bp_pc_at_break", bus.pc, 5);
        check_output("bp_cause", bus.halt_cause, 1);
        check_output("bp_idx_lowest", bus.bp_hit_idx, 0);
        bus.step = 1'b1;
        run_cycles(1);
        bus.step = 1'b0;
        run_cycles(2);
        check_output("bp_released", bus.halted, 0);
        run_cycles(8);
        check_output("bp_stepped_off_pc", bus.pc, 7);
        check_output("bp_no_rebreak", bus.halted, 0);
        bus.run = 1'b0;
        run_cycles(3);

        // Randomised breakpoint scenarios.
        for (int i = 0; i < 4; i++) begin
            pulse_step();
            bus.run = 1'b0;
            run_cycles(20);
            bus.bp_addr  = {6'($urandom_range(0, 10)), 6'($urandom_range(0, 10))};
            bus.bp_valid = 2'($urandom_range(0, 3));
            bus.pc       = 6'($urandom_range(0, 3));
            bus.fast     = 1'($urandom_range(0, 1));
            bus.run      = 1'b1;
            run_cycles(30);
            pulse_step();
            run_cycles(15);
            bus.run = 1'b0;
            run_cycles(5);
        end

        // Reset in the middle of a burst, during an active enable.
        bus.bp_valid = '0;
        pc_follow    = 1'b0;
        bus.fast     = 1'b0;
        pulse_step();
        run_cycles(20);
        bus.burst_n = 4'd3;
        base = en_count;
        pulse_step();
        for (int k = 0; k < 20 && en_count - base < 1; k++) run_cycles(1);
        check_output("burst_first_enable", en_count - base, 1);
        @(negedge clock);
        for (int k = 0; k < 10 && !bus.cpu_en; k++) @(negedge clock);
        check_output("burst_second_enable_seen", bus.cpu_en, 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_reset_cpu_en", bus.cpu_en, 0);
        check_output("async_reset_human_clock", bus.human_clock, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_cycles(2);
        base = en_count;
        bus.step = 1'b1;
        run_cycles(1);
        bus.step = 1'b0;
        run_cycles(20);
        check_output("fresh_burst_count", en_count - base, 3);

        // fast toggles in the middle of counting.
        bus.fast = 1'b1;
        bus.run  = 1'b1;
        run_cycles(5);
        bus.fast = 1'b0;
        run_cycles(6);
        bus.fast = 1'b1;
        run_cycles(4);
        bus.run = 1'b0;
        run_cycles(3);

        // Random soak, first with a CPU-like pc, then with a wandering pc.
        bus.bp_addr  = {6'd3, 6'd6};
        bus.bp_valid = 2'b01;
        for (int k = 0; k < 400; k++) begin
            pc_follow = (k < 200);
            apply_stimulus();
        end
        bus.run        = 1'b0;
        bus.step       = 1'b0;
        bus.monitor_in = 1'b0;
        bus.bp_valid   = '0;
        pc_follow      = 1'b0;
        run_cycles(6);
        pulse_step();
        run_cycles(20);

        // Monitor trip pulse during RUN.
        bus.fast = 1'b0;
        bus.run = 1'b1;
        run_cycles(5);
        bus.monitor_in = 1'b1;
        run_cycles(1);
        bus.monitor_in = 1'b0;
        run_cycles(2);
`ifdef STEP_CLOCK_MONITOR_TRIP_EN
        check_output("trip_halted", bus.halted, 1);
        check_output("trip_cause", bus.halt_cause, 2);
        pulse_step();
        pulse_step();
        check_output("trip_sticky", bus.halted, 1);
        reset = 1'b1;
        #1;
        check_output("trip_reset_halted", bus.halted, 0);
        check_output("trip_reset_cause", bus.halt_cause, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
`else
        check_output("monitor_ignored_halted", bus.halted, 0);
        base = en_count;
        run_cycles(8);
        check_output("monitor_ignored_running", en_count - base, 2);
`endif
        bus.run = 1'b0;
        run_cycles(6);

        check_output("enable_queue_drained", en_q.size(), 0);
        check_output("break_queue_drained", brk_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
